// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode selectors and count sizing.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  // Occupancy must represent 0..depth inclusive, hence one bit more than the address.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one asynchronous read port.
// Contents are never reset; the owning FIFO tracks validity through its pointers.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, almost flags, sticky over/underflow and flush.
// Standard mode: 1-cycle registered read; FWFT: head word shown as soon as it is written.
module sync_fifo_ext
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = count_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0]  AF_T    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_T    = CNT_W'(AE_THRESH);
  localparam logic [ADDR_W:0]   PTR_ONE = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [ADDR_W:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] head;
  logic                  wr_acc, rd_acc;

  // Acceptance looks only at registered flags, so a same-cycle read never frees room for a write.
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = (cnt_q >= AF_T);
  assign almost_empty = (cnt_q <= AE_T);
  assign count        = cnt_q;

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc && !clr && !rst),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(wr_data),
    .raddr(rd_ptr[ADDR_W-1:0]),
    .rdata(head)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      if (w_en && full)  overflow  <= 1'b1;
      if (r_en && empty) underflow <= 1'b1;
    end
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign rd_data = empty ? '0 : head;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_q;
      // A flush leaves the last delivered word visible.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
        end else if (!clr && rd_acc) begin
          rd_q <= head;
        end
      end
      assign rd_data = rd_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO, the next generation of the team's synchronous FIFO. It adds configurable depth, a first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow status and a synchronous flush. It sits between same-clock producer and consumer blocks and is the standard buffer for new datapaths.

## Interface
- DATA_WIDTH, 8: word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- Derived ADDR_W = $clog2(DEPTH).

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; empties the FIFO and clears the sticky flags.
- w_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- r_en  in  1  read request (FWFT: pop/acknowledge).
- rd_data  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

## Operation
- Reset (rst=1 at posedge): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), rd_data=0, overflow=0, underflow=0. Memory contents are not reset.
- Priority: rst > clr > r_en/w_en.
- clr resets pointers, count and sticky flags. rd_data holds its value in standard mode and reads 0 in FWFT.
- Write accepted iff w_en && !full: mem[wr_ptr]=wr_data, wr_ptr++.
- Read accepted iff r_en && !empty: rd_ptr++.
- Acceptance uses registered flags only. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- Rejected write sets overflow. Rejected read sets underflow. Both stay set until rst or clr.
- Count: +1 for write only, −1 for read only, unchanged when both or neither are accepted.
- Pointers are ADDR_W+1 bits and wrap modulo 2·DEPTH. Address is ptr[ADDR_W-1:0]. full/empty are compared from pointers and must agree with count.
- Standard mode: rd_data is registered. It loads mem[rd_ptr] on an accepted read and holds otherwise.
- FWFT mode: rd_data = empty ? 0 : mem[rd_ptr]. The head word is presented without a request, and r_en consumes it.

## Timing
- All outputs are registered state or decoded from registered state; there is no combinational path from w_en/r_en to any flag.
- Write at edge k: count and flags update at k; empty deasserts after k.
- Standard mode: earliest read edge is k+1; data is valid after that edge (1-cycle read latency).
- FWFT mode: the written word appears on rd_data after edge k. Consuming it at edge k+1 shows the next word, or 0 if the FIFO is now empty.
- Full: the DEPTH-th write sets full at that edge. A read at the next edge clears full, and a write is accepted again on the following edge.
- Back-to-back simultaneous read and write at any non-empty, non-full level sustains one word per cycle in each direction.

## Structure
- Package fifo_pkg holds the FWFT mode localparams and a function returning the ADDR_W+1 count width.
- Sub-module fifo_mem: simple dual-port RAM (one write port, one asynchronous read port, no reset), parametrised by DATA_WIDTH/DEPTH.
- Top level holds the pointers, count, flag decode, sticky logic and the read-mode mux.

## Test plan
- Reset, then fill: DEPTH=8, write 0x01..0x08 on consecutive cycles → count steps 1..8. almost_full rises at count=6, full at the 8th write, and empty deasserts after the first write. A 9th write of 0x09 sets overflow, and count stays 8.
- Drain in standard mode: 8 reads → rd_data 0x01..0x08, each one cycle after its read edge. empty asserts after the 8th read, and a 9th read sets underflow with rd_data holding 0x08.
- Wrap-around: 5 writes, 5 reads, then 8 writes and 8 reads of random data, checked against a queue model → all words match, and count and flags agree with the model every cycle.
- Simultaneous access: at count=4, w_en=r_en=1 for 10 cycles → count stays 4 and order is preserved. At full, both high → read only, overflow=1. At empty, both high → write only, underflow=1.
- FWFT=1: write 0xA5 at edge k → rd_data=0xA5 after k with no r_en. r_en at k+1 → rd_data=0 and empty=1.
- clr at count=5 with overflow=1 → next cycle count=0, empty=1, overflow=0. A following write/read of 0x3C returns 0x3C. A rst pulse mid-traffic returns all outputs to their reset values.
